// File: rtl/check_path_clear.sv
// Sequential path walker for sliding pieces: steps one square per clock from the
// source toward the destination and reports whether the line is clear and whether it ends in a capture.
module check_path_clear #(
    parameter logic [3:0] EMPTY_CODE = 4'h0,
    parameter int         COLOR_BIT  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] old_x,
    input  logic [2:0] old_y,
    input  logic [2:0] new_x,
    input  logic [2:0] new_y,
    input  logic       mover_color,
    input  logic [3:0] board_in [0:7][0:7],
    output logic       busy,
    output logic       done,
    output logic       path_clear,
    output logic       capture
);

    typedef enum logic [1:0] {
        PC_IDLE,
        PC_STEP,
        PC_DONE
    } pc_state_t;

    pc_state_t  state_q, state_d;
    logic [2:0] cursor_x_q, cursor_x_d;
    logic [2:0] cursor_y_q, cursor_y_d;
    logic [2:0] step_x_q, step_x_d;
    logic [2:0] step_y_q, step_y_d;
    logic [2:0] dest_x_q, dest_x_d;
    logic [2:0] dest_y_q, dest_y_d;
    logic       color_q, color_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       path_clear_q, path_clear_d;
    logic       capture_q, capture_d;

    // Move decode on the request inputs; dx/dy are 4-bit two's complement differences.
    logic [3:0] dx, dy;
    logic [3:0] abs_dx, abs_dy;
    logic [2:0] req_step_x, req_step_y;
    logic       shape_ok;

    always_comb begin
        dx         = {1'b0, new_x} - {1'b0, old_x};
        dy         = {1'b0, new_y} - {1'b0, old_y};
        abs_dx     = dx[3] ? (4'd0 - dx) : dx;
        abs_dy     = dy[3] ? (4'd0 - dy) : dy;
        req_step_x = (dx == 4'd0) ? 3'd0 : (dx[3] ? 3'b111 : 3'b001);
        req_step_y = (dy == 4'd0) ? 3'd0 : (dy[3] ? 3'b111 : 3'b001);
        shape_ok   = ((dx == 4'd0) != (dy == 4'd0)) ||
                     ((abs_dx == abs_dy) && (abs_dx != 4'd0));
    end

    // Square under the cursor; the caller holds board_in stable for the whole walk.
    logic [3:0] square;
    logic       occupied;
    logic       enemy;
    logic       at_dest;

    always_comb begin
        square   = board_in[cursor_x_q][cursor_y_q];
        occupied = (square != EMPTY_CODE);
        enemy    = (square[COLOR_BIT] != color_q);
        at_dest  = (cursor_x_q == dest_x_q) && (cursor_y_q == dest_y_q);
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        step_x_d     = step_x_q;
        step_y_d     = step_y_q;
        dest_x_d     = dest_x_q;
        dest_y_d     = dest_y_q;
        color_d      = color_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        path_clear_d = path_clear_q;
        capture_d    = capture_q;

        unique case (state_q)
            PC_IDLE: begin
                if (start) begin
                    dest_x_d     = new_x;
                    dest_y_d     = new_y;
                    color_d      = mover_color;
                    step_x_d     = req_step_x;
                    step_y_d     = req_step_y;
                    cursor_x_d   = old_x + req_step_x;
                    cursor_y_d   = old_y + req_step_y;
                    path_clear_d = 1'b0;
                    capture_d    = 1'b0;
                    if (shape_ok) begin
                        state_d = PC_STEP;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = PC_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            PC_STEP: begin
                if (at_dest) begin
                    // Destination may be empty or an enemy; an own piece blocks the move.
                    path_clear_d = !occupied || enemy;
                    capture_d    = occupied && enemy;
                    state_d      = PC_DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                end else if (occupied) begin
                    path_clear_d = 1'b0;
                    capture_d    = 1'b0;
                    state_d      = PC_DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                end else begin
                    cursor_x_d = cursor_x_q + step_x_q;
                    cursor_y_d = cursor_y_q + step_y_q;
                end
            end

            PC_DONE: begin
                state_d = PC_IDLE;
            end

            default: begin
                state_d = PC_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PC_IDLE;
            cursor_x_q   <= 3'd0;
            cursor_y_q   <= 3'd0;
            step_x_q     <= 3'd0;
            step_y_q     <= 3'd0;
            dest_x_q     <= 3'd0;
            dest_y_q     <= 3'd0;
            color_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            path_clear_q <= 1'b0;
            capture_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            dest_x_q     <= dest_x_d;
            dest_y_q     <= dest_y_d;
            color_q      <= color_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            path_clear_q <= path_clear_d;
            capture_q    <= capture_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign path_clear = path_clear_q;
    assign capture    = capture_q;

endmodule

// File: tb/tb_check_path_clear.sv
// Directed self-checking bench for check_path_clear: latency, blocking, capture,
// illegal shapes, ignored start pulses and asynchronous reset mid-walk.
module tb_check_path_clear;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [2:0] old_x, old_y, new_x, new_y;
    logic       mover_color;
    logic [3:0] board [0:7][0:7];
    logic       busy, done, path_clear, capture;

    int checks;
    int errors;

    check_path_clear dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .old_x       (old_x),
        .old_y       (old_y),
        .new_x       (new_x),
        .new_y       (new_y),
        .mover_color (mover_color),
        .board_in    (board),
        .busy        (busy),
        .done        (done),
        .path_clear  (path_clear),
        .capture     (capture)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_board();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                board[x][y] = 4'h0;
    endtask

    // Launch one request and count cycles until done; lat = 0 means no done within the budget.
    task automatic run_move(input logic [2:0] ox, input logic [2:0] oy,
                            input logic [2:0] nx, input logic [2:0] ny,
                            input logic color,
                            output int lat, output logic busy_seen, output logic busy_first);
        @(negedge clk);
        old_x = ox; old_y = oy; new_x = nx; new_y = ny;
        mover_color = color;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_seen = 1'b0;
        busy_first = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) busy_first = busy;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        old_x = 3'd0; old_y = 3'd0; new_x = 3'd0; new_y = 3'd0;
        mover_color = 1'b0;
        clear_board();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (path_clear !== 1'b0) begin errors++; $display("FAIL reset_path_clear: got %b want 0", path_clear); end
        checks++; if (capture !== 1'b0) begin errors++; $display("FAIL reset_capture: got %b want 0", capture); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_diagonal();
        int lat; logic bs, bf;
        clear_board();
        run_move(3'd0, 3'd0, 3'd7, 3'd7, 1'b0, lat, bs, bf);
        checks++; if (lat !== 8) begin errors++; $display("FAIL diag_latency: got %0d want 8", lat); end
        checks++; if (bf !== 1'b1) begin errors++; $display("FAIL diag_busy_rise: got %b want 1", bf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL diag_busy_at_done: got %b want 0", busy); end
        checks++; if (path_clear !== 1'b1) begin errors++; $display("FAIL diag_path_clear: got %b want 1", path_clear); end
        checks++; if (capture !== 1'b0) begin errors++; $display("FAIL diag_capture: got %b want 0", capture); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL diag_done_pulse: got %b want 0", done); end
        checks++; if (path_clear !== 1'b1) begin errors++; $display("FAIL diag_path_clear_hold: got %b want 1", path_clear); end
    endtask

    task automatic test_blocked();
        int lat; logic bs, bf;
        clear_board();
        board[3][0] = 4'h2;
        run_move(3'd0, 3'd0, 3'd7, 3'd0, 1'b0, lat, bs, bf);
        checks++; if (lat !== 4) begin errors++; $display("FAIL block_latency: got %0d want 4", lat); end
        checks++; if (path_clear !== 1'b0) begin errors++; $display("FAIL block_path_clear: got %b want 0", path_clear); end
        checks++; if (capture !== 1'b0) begin errors++; $display("FAIL block_capture: got %b want 0", capture); end
    endtask

    task automatic test_capture();
        int lat; logic bs, bf;
        clear_board();
        board[4][4] = 4'h9;
        run_move(3'd1, 3'd1, 3'd4, 3'd4, 1'b0, lat, bs, bf);
        checks++; if (lat !== 4) begin errors++; $display("FAIL enemy_latency: got %0d want 4", lat); end
        checks++; if (path_clear !== 1'b1) begin errors++; $display("FAIL enemy_path_clear: got %b want 1", path_clear); end
        checks++; if (capture !== 1'b1) begin errors++; $display("FAIL enemy_capture: got %b want 1", capture); end
        board[4][4] = 4'h1;
        run_move(3'd1, 3'd1, 3'd4, 3'd4, 1'b0, lat, bs, bf);
        checks++; if (lat !== 4) begin errors++; $display("FAIL own_latency: got %0d want 4", lat); end
        checks++; if (path_clear !== 1'b0) begin errors++; $display("FAIL own_path_clear: got %b want 0", path_clear); end
        checks++; if (capture !== 1'b0) begin errors++; $display("FAIL own_capture: got %b want 0", capture); end
    endtask

    task automatic test_adjacent();
        int lat; logic bs, bf;
        clear_board();
        board[2][5] = 4'hA;
        run_move(3'd3, 3'd4, 3'd2, 3'd5, 1'b0, lat, bs, bf);
        checks++; if (lat !== 2) begin errors++; $display("FAIL adj_latency: got %0d want 2", lat); end
        checks++; if (path_clear !== 1'b1) begin errors++; $display("FAIL adj_path_clear: got %b want 1", path_clear); end
        checks++; if (capture !== 1'b1) begin errors++; $display("FAIL adj_capture: got %b want 1", capture); end
    endtask

    task automatic test_illegal();
        int lat; logic bs, bf;
        clear_board();
        run_move(3'd0, 3'd0, 3'd2, 3'd1, 1'b0, lat, bs, bf);
        checks++; if (lat !== 1) begin errors++; $display("FAIL knight_latency: got %0d want 1", lat); end
        checks++; if (bs !== 1'b0) begin errors++; $display("FAIL knight_busy: got %b want 0", bs); end
        checks++; if (path_clear !== 1'b0) begin errors++; $display("FAIL knight_path_clear: got %b want 0", path_clear); end
        checks++; if (capture !== 1'b0) begin errors++; $display("FAIL knight_capture: got %b want 0", capture); end
        run_move(3'd3, 3'd3, 3'd3, 3'd3, 1'b0, lat, bs, bf);
        checks++; if (lat !== 1) begin errors++; $display("FAIL same_sq_latency: got %0d want 1", lat); end
        checks++; if (bs !== 1'b0) begin errors++; $display("FAIL same_sq_busy: got %b want 0", bs); end
        checks++; if (path_clear !== 1'b0) begin errors++; $display("FAIL same_sq_path_clear: got %b want 0", path_clear); end
    endtask

    // Extra start pulses on every cycle of the walk and its done cycle must all be dropped.
    task automatic test_back_to_back();
        int done_count;
        int done_cycle;
        clear_board();
        done_count = 0;
        done_cycle = 0;
        @(negedge clk);
        old_x = 3'd7; old_y = 3'd7; new_x = 3'd0; new_y = 3'd0;
        mover_color = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done) begin
                done_count++;
                done_cycle = n;
                if (path_clear !== 1'b1 || capture !== 1'b0) begin
                    checks++; errors++;
                    $display("FAIL b2b_result: got pc=%b cap=%b want pc=1 cap=0", path_clear, capture);
                end
            end
            old_x = 3'd0; old_y = 3'd0; new_x = 3'd0; new_y = 3'd3;
            start = (n <= 8);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++; if (done_count !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", done_count); end
        checks++; if (done_cycle !== 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", done_cycle); end
        checks++; if (path_clear !== 1'b1) begin errors++; $display("FAIL b2b_path_clear: got %b want 1", path_clear); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_requeue: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_walk();
        int lat; logic bs, bf;
        int stray_done;
        clear_board();
        stray_done = 0;
        @(negedge clk);
        old_x = 3'd0; old_y = 3'd0; new_x = 3'd7; new_y = 3'd0;
        mover_color = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b want 0", done); end
        checks++; if (path_clear !== 1'b0 || capture !== 1'b0) begin
            errors++; $display("FAIL mid_reset_result: got pc=%b cap=%b want 0 0", path_clear, capture);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) stray_done++;
        end
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) stray_done++;
        end
        checks++; if (stray_done !== 0) begin errors++; $display("FAIL mid_reset_stray_done: got %0d want 0", stray_done); end
        run_move(3'd0, 3'd0, 3'd0, 3'd5, 1'b0, lat, bs, bf);
        checks++; if (lat !== 6) begin errors++; $display("FAIL post_reset_latency: got %0d want 6", lat); end
        checks++; if (path_clear !== 1'b1) begin errors++; $display("FAIL post_reset_path_clear: got %b want 1", path_clear); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean_diagonal();
        test_blocked();
        test_capture();
        test_adjacent();
        test_illegal();
        test_back_to_back();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
